// File: rtl/shift_r64_seq.sv
// Multi-cycle 64-bit right shifter (logical/arithmetic) with valid/ready on both sides.
// The shift runs as six binary stages (32..1), SPC of them per clock; amounts >= 64 saturate.
module shift_r64_seq #(
    parameter int SPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_n,
    input  logic        in_arith,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] SPC3 = 3'(SPC);

    state_t      state, state_nxt;
    logic [63:0] data, stage_data;
    logic [5:0]  n;
    logic        arith, sign;
    logic [2:0]  cnt;
    logic        last;
    logic        sat;
    logic [64:0] ext;
    logic [2:0]  k;

    // cnt always names the next stage to run, so this is the final pass
    assign last = cnt < SPC3;
    assign sat  = |in_n[7:6];

    // Runs stages cnt, cnt-1, ... SPC deep; the 65-bit sign-extended form
    // gives the fill bit for free on an arithmetic shift.
    always_comb begin
        stage_data = data;
        ext        = '0;
        k          = '0;
        for (int j = 0; j < SPC; j++) begin
            k = cnt - 3'(j);
            if (n[k]) begin
                ext        = {sign & arith, stage_data};
                ext        = $signed(ext) >>> (7'd1 << k);
                stage_data = ext[63:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = sat ? DONE : BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            n     <= '0;
            arith <= 1'b0;
            sign  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n     <= in_n[5:0];
                        arith <= in_arith;
                        sign  <= in_data[63];
                        if (sat) begin
                            data <= {64{in_data[63] & in_arith}};
                        end else begin
                            data <= in_data;
                            cnt  <= 3'd5;
                        end
                    end
                end
                BUSY: begin
                    data <= stage_data;
                    cnt  <= last ? 3'd0 : cnt - SPC3;
                end
                default: ;
            endcase
        end
    end

    assign out_data = data;

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));
    a_cnt: assert property (@(posedge clk) disable iff (rst)
        (state == BUSY) |-> (cnt <= 3'd5));

endmodule

// File: tb/tb_shift_r64_seq.sv
// Bench for shift_r64_seq: one instance per SPC in {1,2,3,6}, each running
// directed cases then random transfers against a plain-arithmetic reference.
module tb_shift_r64_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_shr(input logic [63:0] d, input logic [7:0] n, input logic a);
        if (n >= 8'd64) return (a && d[63]) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
        if (a) return 64'($signed(d) >>> n);
        return d >> n;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g
        localparam int SPCV = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 6;
        localparam int LAT  = 1 + 6 / SPCV;
        localparam int RD   = (LAT - 1 < 3) ? LAT - 1 : 3;

        logic        rst, in_valid, in_ready, in_arith, out_valid, out_ready;
        logic [63:0] in_data, out_data;
        logic [7:0]  in_n;
        logic        done_b = 1'b0;

        shift_r64_seq #(.SPC(SPCV)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready),
            .in_data(in_data), .in_n(in_n), .in_arith(in_arith),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
        );

        task automatic xfer(input logic [63:0] d, input logic [7:0] n, input logic a,
                            input int stall, input logic [63:0] exp, input string tag);
            int lat;
            logic [63:0] hold;
            string t;
            t = $sformatf("spc%0d_%s", SPCV, tag);
            chk({t, "_rdy"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1; in_data = d; in_n = n; in_arith = a;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                chk({t, "_busy_rdy"}, 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                lat++;
            end
            chk({t, "_lat"}, 64'(lat), (n >= 8'd64) ? 64'd1 : 64'(LAT));
            chk({t, "_data"}, out_data, exp);
            hold = out_data;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk({t, "_stall_vld"}, 64'(out_valid), 64'd1);
                chk({t, "_stall_data"}, out_data, hold);
                chk({t, "_stall_rdy"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({t, "_post_vld"}, 64'(out_valid), 64'd0);
            chk({t, "_post_rdy"}, 64'(in_ready), 64'd1);
        endtask

        initial begin
            logic [63:0] d;
            logic [7:0]  n;
            logic        a;
            string       t;
            t = $sformatf("spc%0d", SPCV);
            rst = 1'b1; in_valid = 1'b0; in_data = '0; in_n = '0; in_arith = 1'b0; out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk({t, "_rst_rdy"}, 64'(in_ready), 64'd1);
            chk({t, "_rst_vld"}, 64'(out_valid), 64'd0);
            chk({t, "_rst_data"}, out_data, 64'h0);
            rst = 1'b0;
            @(posedge clk); #1;

            xfer(64'hFFFF_FFFF_FFFF_FFFF, 8'd63, 1'b0, 0, 64'h1, "log63");
            xfer(64'h8000_0000_0000_0000, 8'd4, 1'b1, 0, 64'hF800_0000_0000_0000, "ari4");
            xfer(64'h8000_0000_0000_0000, 8'd4, 1'b0, 0, 64'h0800_0000_0000_0000, "log4");
            xfer(64'h8000_0000_0000_0001, 8'h40, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, "sat_ari");
            xfer(64'h8000_0000_0000_0001, 8'h40, 1'b0, 0, 64'h0, "sat_log");
            xfer(64'h7FFF_0000_1234_5678, 8'hFF, 1'b1, 0, 64'h0, "sat_pos");
            xfer(64'h0123_4567_89AB_CDEF, 8'd0, 1'b0, 5, 64'h0123_4567_89AB_CDEF, "ident");

            // reset while BUSY: request must vanish with no output
            in_valid = 1'b1; in_data = 64'hDEAD_BEEF_CAFE_F00D; in_n = 8'd5; in_arith = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (RD - 1) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk({t, "_mid_rst_rdy"}, 64'(in_ready), 64'd1);
            chk({t, "_mid_rst_vld"}, 64'(out_valid), 64'd0);
            chk({t, "_mid_rst_data"}, out_data, 64'h0);
            #2 rst = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                chk({t, "_post_rst_vld"}, 64'(out_valid), 64'd0);
            end

            for (int i = 0; i < 1500; i++) begin
                d = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) d[63] = 1'b1;
                n = ($urandom_range(0, 99) < 15) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
                a = 1'($urandom_range(0, 1));
                xfer(d, n, a, $urandom_range(0, 3), ref_shr(d, n, a), "rnd");
            end
            done_b = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g[0].done_b && g[1].done_b && g[2].done_b && g[3].done_b) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        nchk++;
        if (cyc >= 60000) begin
            nerr++;
            $display("FAIL timeout got=%0d cycles exp=<60000", cyc);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
